// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file
// and its clear sequencer.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NRD   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: on a clear request walks every register address once,
// one per cycle, flagging the sweep as busy for exactly DEPTH cycles.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int   DEPTH = DEF_DEPTH,
  localparam int  AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic          busy_o,
  output logic          sweep_en_o,
  output logic [AW-1:0] sweep_addr_o
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments only; the comb
  // processes below use blocking assignments with a default first so no
  // latch is inferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        // The last address is cleared on this edge; hold CNT rather than wrap.
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
        else                         cnt_d   = cnt_q + AW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == SWEEP);
    sweep_en_o   = (state_q == SWEEP);
    sweep_addr_o = cnt_q;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with combinational write-through reads, a
// per-register pending scoreboard and a sequential clear sweep.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int  WIDTH   = DEF_WIDTH,
  parameter int  DEPTH   = DEF_DEPTH,
  parameter int  NRD     = DEF_NRD,
  parameter bit  ZERO_R0 = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 WE,
  input  logic [AW-1:0]        Rw,
  input  logic [WIDTH-1:0]     busW,
  input  logic [NRD*AW-1:0]    Ra,
  output logic [NRD*WIDTH-1:0] busR,
  input  logic                 ISSUE,
  input  logic [AW-1:0]        Rd,
  output logic [DEPTH-1:0]     PEND,
  input  logic                 CLR,
  output logic                 BUSY
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic             sweep_en;
  logic [AW-1:0]    sweep_addr;
  logic             wr_ok;
  logic             issue_ok;
  logic             bypass_ok;

  regfile_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
    .clk          (CLK),
    .rst_n        (RST_N),
    .clr_i        (CLR),
    .busy_o       (BUSY),
    .sweep_en_o   (sweep_en),
    .sweep_addr_o (sweep_addr)
  );

  assign wr_ok     = WE && !BUSY && !(ZERO_R0 && (Rw == '0));
  assign issue_ok  = ISSUE && !BUSY && !(ZERO_R0 && (Rd == '0));
  // Bypass is gated by reset so every read is zero while reset is held.
  assign bypass_ok = WE && !BUSY && RST_N;

  // NOTE: the storage array is reset explicitly because its contents must
  // read as zero the instant reset asserts, not after a sweep.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else if (sweep_en) begin
      regs_q[sweep_addr] <= '0;
      pend_q[sweep_addr] <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs_q[Rw] <= busW;
        pend_q[Rw] <= 1'b0;
      end
      // Later assignment wins, so an issue to the written register stays pending.
      if (issue_ok) pend_q[Rd] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = Ra[k*AW +: AW];
    assign busR[k*WIDTH +: WIDTH] =
      (ZERO_R0 && (addr == '0))       ? '0   :
      (bypass_ok && (Rw == addr))     ? busW :
                                        regs_q[addr];
  end

  assign PEND = pend_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench: directed vector table, sweep/reset sequences, random
// traffic against a behavioural model, and a 3-port 16x8 build.
module tb_reg_file_mp;

  localparam int D = 32;

  logic        CLK = 1'b0;
  logic        RST_N;
  always #5 CLK = ~CLK;

  logic        we, issue, clr;
  logic [4:0]  rw, rd;
  logic [31:0] busw;
  logic [4:0]  ra_a [2];
  logic [9:0]  ra;
  logic [63:0] busr;
  logic [31:0] pend;
  logic        busy;
  assign ra = {ra_a[1], ra_a[0]};

  logic        we2, issue2, clr2;
  logic [2:0]  rw2, rd2;
  logic [15:0] busw2;
  logic [8:0]  ra2;
  logic [47:0] busr2;
  logic [7:0]  pend2;
  logic        busy2;

  reg_file_mp u_dut (
    .CLK(CLK), .RST_N(RST_N), .WE(we), .Rw(rw), .busW(busw), .Ra(ra),
    .busR(busr), .ISSUE(issue), .Rd(rd), .PEND(pend), .CLR(clr), .BUSY(busy)
  );

  reg_file_mp #(.WIDTH(16), .DEPTH(8), .NRD(3), .ZERO_R0(1'b1)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .WE(we2), .Rw(rw2), .busW(busw2), .Ra(ra2),
    .busR(busr2), .ISSUE(issue2), .Rd(rd2), .PEND(pend2), .CLR(clr2), .BUSY(busy2)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: register contents, pending flags, cycles of sweep left.
  logic [31:0] m_reg  [D];
  bit          m_pend [D];
  int          m_left;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (m_left == 0 && we && rw == a) return busw;
    return m_reg[a];
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] r;
    for (int i = 0; i < D; i++) r[i] = m_pend[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_reg[i]  = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_left = 0;
  endtask

  task automatic model_step();
    if (m_left > 0) begin
      int idx;
      idx = D - m_left;
      m_reg[idx]  = 32'h0;
      m_pend[idx] = 1'b0;
      m_left--;
    end else begin
      if (we && rw != 5'd0) begin
        m_reg[rw]  = busw;
        m_pend[rw] = 1'b0;
      end
      if (issue && rd != 5'd0) m_pend[rd] = 1'b1;
      if (clr) m_left = D;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; issue = 1'b0; clr = 1'b0;
    rw = 5'd0; rd = 5'd0; busw = 32'h0;
  endtask

  task automatic check_all(string tag);
    check({tag, ".busR0"}, busr[31:0], model_read(ra_a[0]));
    check({tag, ".busR1"}, busr[63:32], model_read(ra_a[1]));
    check({tag, ".BUSY"}, busy, (m_left > 0));
    check({tag, ".PEND"}, pend, model_pend());
  endtask

  function automatic logic [15:0] v2(int i);
    return 16'h1000 + 16'(i) * 16'h0111;
  endfunction

  typedef struct {
    logic        we;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic [4:0]  ra0, ra1;
    logic        issue;
    logic [4:0]  rd;
    logic [31:0] exp_r0, exp_r1;
    logic [4:0]  pidx;
    logic        exp_p;
  } vec_t;

  vec_t vt [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 5'd5, 1'b0};
    vt[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        5'd5, 1'b0};
    vt[2] = '{1'b1, 5'd0, 32'h1234,     5'd0, 5'd5, 1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 5'd0, 1'b0};
    vt[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        5'd0, 1'b0};
    vt[4] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 1'b1, 5'd7, 32'h0,        32'hDEADBEEF, 5'd7, 1'b1};
    vt[5] = '{1'b1, 5'd7, 32'h77,       5'd7, 5'd3, 1'b0, 5'd0, 32'h77,       32'h0,        5'd7, 1'b0};
    vt[6] = '{1'b1, 5'd9, 32'h99,       5'd9, 5'd7, 1'b1, 5'd9, 32'h99,       32'h77,       5'd9, 1'b1};
    vt[7] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 5'd0, 32'h99,       32'h0,        5'd0, 1'b0};
    vt[8] = '{1'b1, 5'd3, 32'hA5A5A5A5, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0,        32'hA5A5A5A5, 5'd3, 1'b0};

    // Reset: a write presented during reset must not bypass.
    RST_N = 1'b0;
    idle();
    we = 1'b1; rw = 5'd5; busw = 32'hDEADBEEF;
    ra_a[0] = 5'd5; ra_a[1] = 5'd0;
    we2 = 1'b0; issue2 = 1'b0; clr2 = 1'b0;
    rw2 = 3'd0; rd2 = 3'd0; busw2 = 16'h0; ra2 = 9'h0;
    model_reset();
    #2;
    check("rst_busR0", busr[31:0], 32'h0);
    check("rst_BUSY", busy, 1'b0);
    check("rst_PEND", pend, 32'h0);
    idle();
    @(negedge CLK) RST_N = 1'b1;
    step();

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      we = vt[i].we; rw = vt[i].rw; busw = vt[i].busw;
      ra_a[0] = vt[i].ra0; ra_a[1] = vt[i].ra1;
      issue = vt[i].issue; rd = vt[i].rd;
      #1;
      check("vec_busR0", busr[31:0], vt[i].exp_r0);
      check("vec_busR1", busr[63:32], vt[i].exp_r1);
      step();
      check("vec_PEND", pend[vt[i].pidx], vt[i].exp_p);
    end
    idle();

    // Fill regs 1..31 with their index, then sweep.
    for (int i = 1; i < D; i++) begin
      we = 1'b1; rw = 5'(i); busw = 32'(i);
      ra_a[0] = 5'(i); ra_a[1] = 5'($urandom_range(0, 31));
      #1 check_all("fill");
      step();
    end
    idle();
    clr = 1'b1;
    #1 check_all("clr");
    step();
    n = 0;
    while (busy && n < 100) begin
      idle();
      ra_a[0] = 5'($urandom_range(0, 31));
      ra_a[1] = 5'($urandom_range(0, 31));
      if (n == 5) begin
        we = 1'b1; rw = 5'd4; busw = 32'hFFFF; ra_a[0] = 5'd4;
      end
      if (n == 8) clr = 1'b1;
      #1 check_all("sweep");
      step();
      n++;
    end
    check("sweep_len", n, 32);
    idle();
    for (int a = 0; a < D; a++) begin
      ra_a[0] = 5'(a); ra_a[1] = 5'(31 - a);
      #1 check("post_sweep", busr[31:0], 32'h0);
    end

    // Reset in the middle of a sweep.
    for (int i = 1; i < D; i++) begin
      we = 1'b1; rw = 5'(i); busw = $urandom;
      issue = 1'b1; rd = 5'(31 - i);
      step();
    end
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1 check_all("pre_rst_sweep");
      step();
    end
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    check("midrst_BUSY", busy, 1'b0);
    check("midrst_PEND", pend, 32'h0);
    for (int a = 0; a < 8; a++) begin
      ra_a[0] = 5'(a * 4 + 1); ra_a[1] = 5'(a * 4 + 3);
      #1;
      check("midrst_busR0", busr[31:0], 32'h0);
      check("midrst_busR1", busr[63:32], 32'h0);
    end
    @(negedge CLK) RST_N = 1'b1;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      #1 check_all("resweep");
      step();
      n++;
    end
    check("resweep_len", n, 32);

    // Random traffic against the model.
    for (int t = 0; t < 400; t++) begin
      we = 1'($urandom_range(0, 1));
      rw = 5'($urandom_range(0, 31));
      busw = $urandom;
      issue = ($urandom_range(0, 3) == 0);
      rd = 5'($urandom_range(0, 31));
      clr = ($urandom_range(0, 59) == 0);
      ra_a[0] = $urandom_range(0, 3) == 0 ? rw : 5'($urandom_range(0, 31));
      ra_a[1] = 5'($urandom_range(0, 31));
      #1 check_all("rand");
      step();
    end
    idle();
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("rand_drain", busy, 1'b0);

    // Three-port 16x8 build.
    for (int i = 1; i < 8; i++) begin
      we2 = 1'b1; rw2 = 3'(i); busw2 = v2(i);
      step();
    end
    we2 = 1'b0;
    ra2 = {3'd6, 3'd5, 3'd3};
    #1;
    check("p3_port0", busr2[15:0],  v2(3));
    check("p3_port1", busr2[31:16], v2(5));
    check("p3_port2", busr2[47:32], v2(6));
    ra2 = {3'd0, 3'd1, 3'd7};
    #1;
    check("p3_port0b", busr2[15:0],  v2(7));
    check("p3_port1b", busr2[31:16], v2(1));
    check("p3_port2b", busr2[47:32], 16'h0);
    we2 = 1'b1; rw2 = 3'd2; busw2 = 16'hBEEF;
    ra2 = {3'd2, 3'd4, 3'd2};
    #1;
    check("p3_byp0", busr2[15:0],  16'hBEEF);
    check("p3_byp1", busr2[31:16], v2(4));
    check("p3_byp2", busr2[47:32], 16'hBEEF);
    check("p3_BUSY", busy2, 1'b0);
    step();
    we2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
